// File: rtl/mem_arbiter_if.sv
// Wishbone-style single-port memory bus used on both sides of mem_arbiter.
//  adr      : word/byte address
//  wdat     : write data (master -> slave)
//  rdat     : read data  (slave -> master)
//  we       : write enable
//  byte_sel : byte access
//  stb      : request, held until ack or abort
//  ack      : single-cycle completion pulse
// master modport: the side issuing requests; slave modport: the side answering them.
interface mem_arbiter_if #(
  parameter int unsigned ADR_W = 20,
  parameter int unsigned DAT_W = 16
);
  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] wdat;
  logic [DAT_W-1:0] rdat;
  logic             we;
  logic             byte_sel;
  logic             stb;
  logic             ack;

  modport master (
    output adr, wdat, we, byte_sel, stb,
    input  rdat, ack
  );

  modport slave (
    input  adr, wdat, we, byte_sel, stb,
    output rdat, ack
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the SRAM/flash memory controller.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TMO_W          = 7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [19:0] m0_adr_i,
  input  logic [15:0] m0_dat_i,
  output logic [15:0] m0_dat_o,
  input  logic        m0_we_i,
  input  logic        m0_byte_i,
  input  logic        m0_stb_i,
  output logic        m0_ack_o,
  input  logic [19:0] m1_adr_i,
  input  logic [15:0] m1_dat_i,
  output logic [15:0] m1_dat_o,
  input  logic        m1_we_i,
  input  logic        m1_byte_i,
  input  logic        m1_stb_i,
  output logic        m1_ack_o,
  output logic [19:0] s_adr_o,
  output logic [15:0] s_dat_o,
  input  logic [15:0] s_dat_i,
  output logic        s_we_o,
  output logic        s_byte_o,
  output logic        s_stb_o,
  input  logic        s_ack_i,
  output logic        tmo_err_o
);

  localparam int unsigned DAT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_q,  last_d;
  logic   stb_q,   stb_d;
  logic   gnt_stb_c;
  logic   tmo_hit_c;
  logic   ack_c;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Expiry only while the granted master still requests; a real ack wins.
  assign tmo_hit_c = (state_q == BUSY) && (cnt_q == TMO_LAST) && !s_ack_i && gnt_stb_c;
  assign tmo_err_o = err_q;
`else
  assign tmo_hit_c = 1'b0;
  assign tmo_err_o = 1'b0;
`endif

  // Request line of the granted master.
  assign gnt_stb_c = grant_q ? m1_stb_i : m0_stb_i;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    stb_d   = stb_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (m0_stb_i || m1_stb_i) begin
          grant_d = (m0_stb_i && m1_stb_i) ? !last_q : m1_stb_i;
          stb_d   = 1'b1;
          state_d = BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        if (s_ack_i) begin
          stb_d   = 1'b0;
          last_d  = grant_q;
          state_d = RELEASE;
        end else if (!gnt_stb_c) begin
          stb_d   = 1'b0;
          state_d = RELEASE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (tmo_hit_c) begin
          stb_d   = 1'b0;
          last_d  = grant_q;
          err_d   = 1'b1;
          state_d = RELEASE;
        end else begin
          cnt_d   = cnt_q + TMO_W'(1);
        end
`endif
      end
      RELEASE: begin
        stb_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        stb_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      stb_q   <= stb_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Timeout counter and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

  // Request mux onto the controller port.
  assign s_adr_o  = grant_q ? m1_adr_i  : m0_adr_i;
  assign s_dat_o  = grant_q ? m1_dat_i  : m0_dat_i;
  assign s_we_o   = grant_q ? m1_we_i   : m0_we_i;
  assign s_byte_o = grant_q ? m1_byte_i : m0_byte_i;
  assign s_stb_o  = stb_q;

  // Ack and read data routing to the granted master.
  assign ack_c    = (s_ack_i || tmo_hit_c) && (state_q == BUSY);
  assign m0_ack_o = ack_c && !grant_q;
  assign m1_ack_o = ack_c &&  grant_q;
  assign m0_dat_o = (tmo_hit_c && !grant_q) ? {DAT_W{1'b1}} : s_dat_i;
  assign m1_dat_o = (tmo_hit_c &&  grant_q) ? {DAT_W{1'b1}} : s_dat_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single transactions plus
// hand-written abort, reset and timeout sequences.
module tb_mem_arbiter;

  logic clk_i = 1'b0;
  logic rst_i;
  logic tmo_err_o;

  logic [19:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [15:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic        m0_we_i, m1_we_i, s_we_o;
  logic        m0_byte_i, m1_byte_i, s_byte_o;
  logic        m0_stb_i, m1_stb_i, s_stb_o;
  logic        m0_ack_o, m1_ack_o, s_ack_i;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.TIMEOUT_CYCLES(8), .TMO_W(7)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .m0_adr_i  (m0_adr_i),
    .m0_dat_i  (m0_dat_i),
    .m0_dat_o  (m0_dat_o),
    .m0_we_i   (m0_we_i),
    .m0_byte_i (m0_byte_i),
    .m0_stb_i  (m0_stb_i),
    .m0_ack_o  (m0_ack_o),
    .m1_adr_i  (m1_adr_i),
    .m1_dat_i  (m1_dat_i),
    .m1_dat_o  (m1_dat_o),
    .m1_we_i   (m1_we_i),
    .m1_byte_i (m1_byte_i),
    .m1_stb_i  (m1_stb_i),
    .m1_ack_o  (m1_ack_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_dat_i   (s_dat_i),
    .s_we_o    (s_we_o),
    .s_byte_o  (s_byte_o),
    .s_stb_o   (s_stb_o),
    .s_ack_i   (s_ack_i),
    .tmo_err_o (tmo_err_o)
  );

  typedef struct {
    bit          m0_req;
    bit          m1_req;
    logic [19:0] adr0;
    logic [19:0] adr1;
    logic [15:0] wd0;
    logic [15:0] wd1;
    bit          we0;
    bit          we1;
    bit          by0;
    bit          by1;
    logic [15:0] rd;
    int          delay;
    bit          exp_gnt;
  } txn_t;

  txn_t tbl[7];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_stb(input string tag);
    int lat;
    lat = 99;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (s_stb_o === 1'b1) begin
        lat = i;
        break;
      end
    end
    check({tag, " stb_latency"}, 32'(lat), 32'd1);
  endtask

  task automatic run_txn(input string tag, input txn_t t);
    logic [19:0] w_adr;
    logic [17:0] w_ctl;
    w_adr = t.exp_gnt ? t.adr1 : t.adr0;
    w_ctl = t.exp_gnt ? {t.wd1, t.we1, t.by1} : {t.wd0, t.we0, t.by0};
    m0_adr_i = t.adr0; m0_dat_i = t.wd0; m0_we_i = t.we0; m0_byte_i = t.by0;
    m1_adr_i = t.adr1; m1_dat_i = t.wd1; m1_we_i = t.we1; m1_byte_i = t.by1;
    m0_stb_i = t.m0_req;
    m1_stb_i = t.m1_req;
    wait_stb(tag);
    for (int c = 0; c < t.delay; c++) begin
      check({tag, " early_ack"}, 32'({m1_ack_o, m0_ack_o}), 32'd0);
      check({tag, " mux_adr"}, 32'(s_adr_o), 32'(w_adr));
      check({tag, " mux_ctl"}, 32'({s_dat_o, s_we_o, s_byte_o}), 32'(w_ctl));
      check({tag, " stb_held"}, 32'(s_stb_o), 32'd1);
      step();
    end
    s_dat_i = t.rd;
    s_ack_i = 1'b1;
    #1;
    check({tag, " ack_route"}, 32'({m1_ack_o, m0_ack_o}), t.exp_gnt ? 32'd2 : 32'd1);
    check({tag, " rdat"}, 32'(t.exp_gnt ? m1_dat_o : m0_dat_o), 32'(t.rd));
    check({tag, " mux_adr_ack"}, 32'(s_adr_o), 32'(w_adr));
    step();
    s_ack_i  = 1'b0;
    m0_stb_i = 1'b0;
    m1_stb_i = 1'b0;
    check({tag, " release_stb"}, 32'({s_stb_o, m1_ack_o, m0_ack_o}), 32'd0);
    step();
    check({tag, " idle_stb"}, 32'(s_stb_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    //           m0    m1    adr0       adr1       wd0       wd1       we0   we1   by0   by1   rd        dly gnt
    tbl[0] = '{1'b1, 1'b0, 20'h01234, 20'h00000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF, 5, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 20'h00100, 20'hC0010, 16'h1111, 16'h55AA, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 3, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 20'h00200, 20'hC0020, 16'h2222, 16'h3333, 1'b1, 1'b0, 1'b0, 1'b1, 16'hA5A5, 1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 20'h00300, 20'hC0030, 16'h4444, 16'h6666, 1'b0, 1'b0, 1'b1, 1'b0, 16'h5A5A, 0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 20'h00400, 20'hC0040, 16'h7777, 16'h8888, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0F0F, 2, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 20'h00500, 20'hFFFFF, 16'h9999, 16'hAAAA, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1357, 1, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 20'h00000, 20'h00600, 16'hFFFF, 16'hBBBB, 1'b1, 1'b0, 1'b0, 1'b0, 16'h2468, 0, 1'b0};

    rst_i = 1'b1;
    m0_adr_i = '0; m0_dat_i = '0; m0_we_i = 1'b0; m0_byte_i = 1'b0; m0_stb_i = 1'b0;
    m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 1'b0; m1_byte_i = 1'b0; m1_stb_i = 1'b0;
    s_dat_i = '0; s_ack_i = 1'b0;
    step();
    step();
    check("reset outputs", 32'({s_stb_o, m1_ack_o, m0_ack_o, tmo_err_o}), 32'd0);
    rst_i = 1'b0;
    step();

    for (int i = 0; i < 7; i++) run_txn($sformatf("txn%0d", i), tbl[i]);

    m1_adr_i = 20'h0ABCD;
    m1_stb_i = 1'b1;
    wait_stb("abort");
    step();
    m1_stb_i = 1'b0;
    #1;
    check("abort no_ack", 32'({m1_ack_o, m0_ack_o}), 32'd0);
    step();
    check("abort stb_drop", 32'({s_stb_o, m1_ack_o, m0_ack_o}), 32'd0);
    step();
    check("abort idle_stb", 32'(s_stb_o), 32'd0);
    t = tbl[1];
    run_txn("post_abort", t);

    run_txn("pre_reset", tbl[6]);
    m0_stb_i = 1'b1;
    m1_stb_i = 1'b1;
    wait_stb("mid_reset");
    check("mid_reset grant", 32'(s_adr_o), 32'(20'h00600));
    step();
    rst_i = 1'b1;
    s_ack_i = 1'b1;
    step();
    check("mid_reset outputs", 32'({s_stb_o, m1_ack_o, m0_ack_o}), 32'd0);
    rst_i = 1'b0;
    s_ack_i = 1'b0;
    m0_stb_i = 1'b0;
    m1_stb_i = 1'b0;
    step();
    t = tbl[2];
    run_txn("post_reset", t);

`ifdef MEM_ARB_TIMEOUT_EN
    begin
      int n;
      m0_adr_i = 20'h0DEAD;
      m0_stb_i = 1'b1;
      s_dat_i  = 16'h1234;
      wait_stb("timeout");
      n = 1;
      while (m0_ack_o !== 1'b1 && n < 20) begin
        step();
        n++;
      end
      check("timeout ack_cycle", 32'(n), 32'd8);
      check("timeout rdat", 32'(m0_dat_o), 32'hFFFF);
      check("timeout m1_ack", 32'(m1_ack_o), 32'd0);
      step();
      m0_stb_i = 1'b0;
      check("timeout err_stb", 32'({tmo_err_o, s_stb_o}), 32'd2);
      step();
      check("timeout err_sticky", 32'(tmo_err_o), 32'd1);
    end
`else
    check("tmo_err tied", 32'(tmo_err_o), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
